// File: rtl/debug_host_ctrl_pkg.sv
// Shared definitions for the debug-unit host controller: command bytes,
// response sizing and FSM state encoding.
package debug_host_ctrl_pkg;

    // Command bytes understood by the debug unit.
    localparam logic [7:0] CMD_WRITE_IM     = 8'd1;
    localparam logic [7:0] CMD_START        = 8'd2;
    localparam logic [7:0] CMD_STEP_BY_STEP = 8'd3;
    localparam logic [7:0] CMD_SEND_BR      = 8'd4;
    localparam logic [7:0] CMD_SEND_MEM     = 8'd5;
    localparam logic [7:0] CMD_SEND_PC      = 8'd6;
    localparam logic [7:0] CMD_STEP         = 8'd7;
    localparam logic [7:0] CMD_CONTINUE     = 8'd8;

    localparam int BYTES_PER_WORD = 4;
    localparam int PC_BYTES       = 1;
    localparam int CNT_W          = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_CMD_TX,
        ST_PROG_FETCH,
        ST_PROG_LATCH,
        ST_SEND_PROG,
        ST_WAIT_PROG_TX,
        ST_RECV,
        ST_DONE
    } state_e;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op >= CMD_WRITE_IM) && (op <= CMD_CONTINUE);
    endfunction

    function automatic logic has_pc(input logic [7:0] op);
        return (op == CMD_SEND_PC) || (op == CMD_STEP);
    endfunction

    function automatic logic [CNT_W-1:0] resp_bytes(input logic [7:0] op,
                                                    input int n_regs,
                                                    input int n_dm);
        int n;
        n = 0;
        case (op)
            CMD_SEND_PC:  n = PC_BYTES;
            CMD_SEND_BR:  n = BYTES_PER_WORD * n_regs;
            CMD_SEND_MEM: n = BYTES_PER_WORD * n_dm;
            CMD_STEP:     n = PC_BYTES + BYTES_PER_WORD * (n_regs + n_dm);
            default:      n = 0;
        endcase
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/debug_host_ctrl_if.sv
// Op request, program ROM, UART TX/RX and capture-buffer signals of the host controller.
interface debug_host_ctrl_if #(
    parameter int NB_CAP_ADDR = 7
);
    logic                   i_op_valid;
    logic [7:0]             i_op;
    logic [7:0]             o_prog_addr;
    logic [31:0]            i_prog_data;
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;
    logic                   i_rx_done;
    logic [7:0]             i_rx_data;
    logic                   o_cap_we;
    logic [NB_CAP_ADDR-1:0] o_cap_addr;
    logic [31:0]            o_cap_data;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_timeout;

    modport master (
        input  i_op_valid, i_op, i_prog_data, i_tx_done, i_rx_done, i_rx_data,
        output o_prog_addr, o_tx_data, o_tx_start, o_cap_we, o_cap_addr,
               o_cap_data, o_busy, o_done, o_timeout
    );

    modport slave (
        output i_op_valid, i_op, i_prog_data, i_tx_done, i_rx_done, i_rx_data,
        input  o_prog_addr, o_tx_data, o_tx_start, o_cap_we, o_cap_addr,
               o_cap_data, o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/debug_rx_packer.sv
// Packs the response byte stream into 32-bit capture words: optional leading
// PC byte stored alone, then MSB-first groups of four bytes.
module debug_rx_packer
    import debug_host_ctrl_pkg::*;
#(
    parameter int NB_CAP_ADDR = 7
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   clear,
    input  logic                   pc_first,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   cap_we,
    output logic [NB_CAP_ADDR-1:0] cap_addr,
    output logic [31:0]            cap_data,
    output logic [CNT_W-1:0]       byte_cnt
);

    logic [1:0]  lane;
    logic [23:0] shift;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lane     <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            cap_addr <= '0;
            cap_we   <= 1'b0;
            cap_data <= '0;
        end else if (clear) begin
            lane     <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            cap_addr <= '0;
            cap_we   <= 1'b0;
        end else begin
            cap_we <= 1'b0;
            // Address advances after each write and sticks at the top entry.
            if (cap_we && (cap_addr != '1))
                cap_addr <= cap_addr + 1'b1;
            if (byte_valid) begin
                byte_cnt <= byte_cnt + 1'b1;
                if (pc_first && (byte_cnt == '0)) begin
                    cap_data <= {24'b0, byte_data};
                    cap_we   <= 1'b1;
                end else begin
                    shift <= {shift[15:0], byte_data};
                    lane  <= lane + 1'b1;
                    if (lane == 2'd3) begin
                        cap_data <= {shift, byte_data};
                        cap_we   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/debug_host_ctrl.sv
// Host-side initiator for the debug-unit protocol: sends a command and program
// words over UART, then captures the response stream with a timeout guard.
module debug_host_ctrl
    import debug_host_ctrl_pkg::*;
#(
    parameter int PROG_WORDS     = 11,
    parameter int N_REGS         = 32,
    parameter int N_DM           = 32,
    parameter int NB_CAP_ADDR    = 7,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input logic                i_clock,
    input logic                i_reset,
    debug_host_ctrl_if.master  bus
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                 state, state_nx;
    logic [7:0]             op;
    logic [7:0]             prog_idx;
    logic [31:0]            prog_word;
    logic [1:0]             byte_sel;
    logic [TO_W-1:0]        timer;
    logic [CNT_W-1:0]       byte_cnt, exp_bytes;
    logic                   accept, rx_valid, recv_last, timeout_hit;
    logic                   cap_we;
    logic [NB_CAP_ADDR-1:0] cap_addr;
    logic [31:0]            cap_data;

    assign accept      = (state == ST_IDLE) && bus.i_op_valid && is_valid_op(bus.i_op);
    assign exp_bytes   = resp_bytes(op, N_REGS, N_DM);
    assign rx_valid    = (state == ST_RECV) && bus.i_rx_done && (byte_cnt < exp_bytes);
    assign recv_last   = cap_we && (byte_cnt == exp_bytes);
    assign timeout_hit = (state == ST_RECV) && !bus.i_rx_done && !recv_last &&
                         (timer == TO_W'(TIMEOUT_CYCLES - 1));

    debug_rx_packer #(.NB_CAP_ADDR(NB_CAP_ADDR)) u_packer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .clear      (accept),
        .pc_first   (has_pc(op)),
        .byte_valid (rx_valid),
        .byte_data  (bus.i_rx_data),
        .cap_we     (cap_we),
        .cap_addr   (cap_addr),
        .cap_data   (cap_data),
        .byte_cnt   (byte_cnt)
    );

    assign bus.o_cap_we      = cap_we;
    assign bus.o_cap_addr    = cap_addr;
    assign bus.o_cap_data    = cap_data;
    assign bus.o_prog_addr   = prog_idx;
    assign bus.o_timeout     = timeout_hit;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        bus.o_tx_data  = 8'h00;
        bus.o_tx_start = 1'b0;
        bus.o_busy     = (state != ST_IDLE);
        bus.o_done     = 1'b0;
        case (state)
            ST_IDLE:        if (accept) state_nx = ST_SEND_CMD;
            ST_SEND_CMD: begin
                bus.o_tx_data  = op;
                bus.o_tx_start = 1'b1;
                state_nx       = ST_WAIT_CMD_TX;
            end
            ST_WAIT_CMD_TX: begin
                bus.o_tx_data = op;
                if (bus.i_tx_done) begin
                    case (op)
                        CMD_WRITE_IM: state_nx = ST_PROG_FETCH;
                        CMD_SEND_BR, CMD_SEND_MEM, CMD_SEND_PC, CMD_STEP:
                                      state_nx = ST_RECV;
                        default:      state_nx = ST_DONE;
                    endcase
                end
            end
            ST_PROG_FETCH:  state_nx = ST_PROG_LATCH;
            ST_PROG_LATCH:  state_nx = ST_SEND_PROG;
            ST_SEND_PROG: begin
                bus.o_tx_data  = prog_word[{byte_sel, 3'b000} +: 8];
                bus.o_tx_start = 1'b1;
                state_nx       = ST_WAIT_PROG_TX;
            end
            ST_WAIT_PROG_TX: begin
                bus.o_tx_data = prog_word[{byte_sel, 3'b000} +: 8];
                if (bus.i_tx_done) begin
                    if (byte_sel != 2'd3)                   state_nx = ST_SEND_PROG;
                    else if (prog_idx == 8'(PROG_WORDS - 1)) state_nx = ST_DONE;
                    else                                    state_nx = ST_PROG_FETCH;
                end
            end
            ST_RECV: begin
                if (recv_last)        state_nx = ST_DONE;
                else if (timeout_hit) state_nx = ST_IDLE;
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                state_nx   = ST_IDLE;
            end
            default:        state_nx = ST_IDLE;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            op        <= '0;
            prog_idx  <= '0;
            prog_word <= '0;
            byte_sel  <= '0;
            timer     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op       <= bus.i_op;
                prog_idx <= '0;
                byte_sel <= '0;
            end
            if (state == ST_PROG_LATCH)
                prog_word <= bus.i_prog_data;
            if ((state == ST_WAIT_PROG_TX) && bus.i_tx_done) begin
                byte_sel <= byte_sel + 1'b1;
                if ((byte_sel == 2'd3) && (prog_idx != 8'(PROG_WORDS - 1)))
                    prog_idx <= prog_idx + 1'b1;
            end
            // Timeout counts idle cycles between response bytes.
            if ((state_nx == ST_RECV) && ((state != ST_RECV) || bus.i_rx_done))
                timer <= '0;
            else if (state == ST_RECV)
                timer <= timer + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Directed self-checking bench for debug_host_ctrl with UART TX responder,
// program ROM model and capture-buffer monitor.
module tb_debug_host_ctrl;
    import debug_host_ctrl_pkg::*;

    localparam int PROG_WORDS     = 11;
    localparam int N_REGS         = 32;
    localparam int N_DM           = 32;
    localparam int NB_CAP_ADDR    = 7;
    localparam int TIMEOUT_CYCLES = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_host_ctrl_if #(.NB_CAP_ADDR(NB_CAP_ADDR)) bus ();

    debug_host_ctrl #(
        .PROG_WORDS     (PROG_WORDS),
        .N_REGS         (N_REGS),
        .N_DM           (N_DM),
        .NB_CAP_ADDR    (NB_CAP_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] tx_log  [0:511];
    logic [31:0] cap_mem [0:127];
    int tx_n = 0, we_n = 0, done_n = 0, to_n = 0, tx_cd = 0;
    int cyc = 0, last_rx_cyc = 0, to_cyc = 0;
    int tx_b, we_b, done_b, to_b;

    // Monitor, UART TX responder and combinational-style program ROM.
    always @(negedge clk) begin
        cyc++;
        bus.i_tx_done = 1'b0;
        if (tx_cd != 0) begin
            tx_cd--;
            if (tx_cd == 0) bus.i_tx_done = 1'b1;
        end
        if (bus.o_tx_start) begin
            if (tx_n < 512) tx_log[tx_n] = 32'(bus.o_tx_data);
            tx_n++;
            tx_cd = 3;
        end
        if (bus.o_cap_we) begin
            cap_mem[bus.o_cap_addr] = bus.o_cap_data;
            we_n++;
        end
        if (bus.o_done) done_n++;
        if (bus.o_timeout) begin
            to_n++;
            to_cyc = cyc;
        end
        if (bus.i_rx_done) last_rx_cyc = cyc;
        bus.i_prog_data = 32'h1122_3300 + 32'(bus.o_prog_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        tx_b = tx_n; we_b = we_n; done_b = done_n; to_b = to_n;
    endtask

    task automatic issue(input logic [7:0] op);
        bus.i_op_valid = 1'b1;
        bus.i_op       = op;
        tick(1);
        bus.i_op_valid = 1'b0;
        bus.i_op       = 8'h00;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick(1);
        bus.i_rx_done = 1'b0;
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 3; j >= 0; j--) send_rx(w[8*j +: 8]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.o_busy && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     32'(bus.o_busy),      32'd0);
        check({tag, "_tx_start"}, 32'(bus.o_tx_start),  32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data),   32'd0);
        check({tag, "_prog_addr"},32'(bus.o_prog_addr), 32'd0);
        check({tag, "_cap_we"},   32'(bus.o_cap_we),    32'd0);
        check({tag, "_cap_addr"}, 32'(bus.o_cap_addr),  32'd0);
        check({tag, "_cap_data"}, bus.o_cap_data,       32'd0);
        check({tag, "_done"},     32'(bus.o_done),      32'd0);
        check({tag, "_timeout"},  32'(bus.o_timeout),   32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int n;
        bus.i_op_valid = 1'b0;
        bus.i_op       = 8'h00;
        bus.i_rx_done  = 1'b0;
        bus.i_rx_data  = 8'h00;

        // Reset state.
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        // Out-of-range op codes are ignored.
        issue(8'd9);
        check("op9_ignored", 32'(bus.o_busy), 32'd0);
        issue(8'd0);
        check("op0_ignored", 32'(bus.o_busy), 32'd0);

        // WRITE_IM: command byte then 11 words LSB first; START mid-flight is dropped.
        snap();
        issue(CMD_WRITE_IM);
        check("wim_busy", 32'(bus.o_busy), 32'd1);
        tick(5);
        issue(CMD_START);
        wait_idle("wim_idle", 2000);
        check("wim_tx_count", 32'(tx_n - tx_b), 32'd45);
        check("wim_cmd_byte", tx_log[tx_b], 32'h01);
        for (int k = 0; k < PROG_WORDS; k++) begin
            w = 32'h1122_3300 + 32'(k);
            for (int j = 0; j < 4; j++)
                check($sformatf("wim_w%0d_b%0d", k, j), tx_log[tx_b + 1 + 4*k + j], {24'b0, w[8*j +: 8]});
        end
        check("wim_done", 32'(done_n - done_b), 32'd1);
        check("wim_no_cap", 32'(we_n - we_b), 32'd0);

        // SEND_PC, with a stray RX byte in IDLE first.
        snap();
        send_rx(8'h55);
        issue(CMD_SEND_PC);
        tick(10);
        send_rx(8'h2C);
        wait_idle("pc_idle", 200);
        check("pc_cmd_byte", tx_log[tx_b], 32'h06);
        check("pc_cap0", cap_mem[0], 32'h0000_002C);
        check("pc_we_count", 32'(we_n - we_b), 32'd1);
        check("pc_done", 32'(done_n - done_b), 32'd1);
        check("pc_no_timeout", 32'(to_n - to_b), 32'd0);

        // SEND_BR: 32 registers MSB first.
        snap();
        issue(CMD_SEND_BR);
        tick(10);
        for (int k = 0; k < N_REGS; k++) send_word(32'hA000_0000 + 32'(k));
        wait_idle("br_idle", 200);
        check("br_we_count", 32'(we_n - we_b), 32'd32);
        check("br_done", 32'(done_n - done_b), 32'd1);
        for (int k = 0; k < N_REGS; k++)
            check($sformatf("br_cap%0d", k), cap_mem[k], 32'hA000_0000 + 32'(k));

        // STEP: PC byte, registers, data memory.
        snap();
        issue(CMD_STEP);
        tick(10);
        send_rx(8'h08);
        for (int k = 0; k < N_REGS; k++) send_word(32'hA000_0000 + 32'(k));
        for (int k = 0; k < N_DM; k++)   send_word(32'hD000_0000 + 32'(4*k));
        wait_idle("step_idle", 200);
        check("step_we_count", 32'(we_n - we_b), 32'd65);
        check("step_done", 32'(done_n - done_b), 32'd1);
        check("step_cap0", cap_mem[0], 32'h0000_0008);
        check("step_cap1", cap_mem[1], 32'hA000_0000);
        check("step_cap32", cap_mem[32], 32'hA000_001F);
        check("step_cap33", cap_mem[33], 32'hD000_0000);
        check("step_cap64", cap_mem[64], 32'hD000_007C);
        check("step_final_addr", 32'(bus.o_cap_addr), 32'd65);

        // SEND_MEM starved after 6 bytes: timeout, one capture, then recovery.
        snap();
        issue(CMD_SEND_MEM);
        tick(10);
        send_word(32'h1122_3344);
        send_rx(8'h55);
        send_rx(8'h66);
        n = 0;
        while (to_n == to_b && n < 300) begin
            tick(1);
            n++;
        end
        check("mem_timeout_count", 32'(to_n - to_b), 32'd1);
        check("mem_timeout_delay", 32'(to_cyc - last_rx_cyc), 32'(TIMEOUT_CYCLES));
        tick(2);
        check("mem_we_count", 32'(we_n - we_b), 32'd1);
        check("mem_cap0", cap_mem[0], 32'h1122_3344);
        check("mem_no_done", 32'(done_n - done_b), 32'd0);
        check("mem_busy_low", 32'(bus.o_busy), 32'd0);
        snap();
        issue(CMD_START);
        wait_idle("after_to_idle", 200);
        check("after_to_cmd", tx_log[tx_b], 32'h02);
        check("after_to_done", 32'(done_n - done_b), 32'd1);

        // Reset in the middle of program streaming.
        snap();
        issue(CMD_WRITE_IM);
        tick(20);
        check("prog_rst_busy_before", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check_outputs_zero("prog_rst");
        tick(1);
        rst = 1'b0;
        tick(10);
        check("prog_rst_no_done", 32'(done_n - done_b), 32'd0);
        check("prog_rst_no_timeout", 32'(to_n - to_b), 32'd0);

        // Reset after 50 bytes of a SEND_BR response.
        snap();
        issue(CMD_SEND_BR);
        tick(10);
        for (int i = 0; i < 50; i++) begin
            w = 32'hA000_0000 + 32'(i / 4);
            send_rx(w[8*(3 - (i % 4)) +: 8]);
        end
        check("br_rst_we_before", 32'(we_n - we_b), 32'd12);
        rst = 1'b1;
        tick(1);
        check_outputs_zero("br_rst");
        tick(1);
        rst = 1'b0;
        tick(150);
        check("br_rst_no_done", 32'(done_n - done_b), 32'd0);
        check("br_rst_no_timeout", 32'(to_n - to_b), 32'd0);
        check("br_rst_no_more_we", 32'(we_n - we_b), 32'd12);
        snap();
        issue(CMD_START);
        wait_idle("rst_start_idle", 200);
        check("rst_start_tx_count", 32'(tx_n - tx_b), 32'd1);
        check("rst_start_cmd", tx_log[tx_b], 32'h02);
        check("rst_start_done", 32'(done_n - done_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
